fetch_stage: RTL and testbench

- Instruction-fetch stage for the multi-cycle/pipelined LoongArch core; sits directly upstream of decode.
- Owns the PC and drives the synchronous inst SRAM, which has one-cycle read latency.
- Hands {pc, inst} to decode over a valid/allowin handshake.
- Accepts branch/jump redirects from decode; holds returned instructions in a one-entry buffer while decode stalls.

---
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the LoongArch core, directly upstream of decode.
// Owns the PC, issues reads to a synchronous inst SRAM (one-cycle latency),
// and offers {pc, inst} to decode over a valid/allowin handshake. While decode
// stalls, the instruction returned by the SRAM is captured in a one-entry
// buffer because the SRAM read data is only valid for a single cycle.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   inst_sram_*          SRAM request (en/addr), write side tied off, rdata in
//   ds_allowin           decode can accept an instruction this cycle
//   br_taken/br_target   redirect pulse and target from decode
//   fs_to_ds_*           valid, pc and instruction word offered to decode
//   fetch_cnt            number of accepted handoffs (wraps)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_sram_en,
  output logic              inst_sram_we,
  output logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_wdata,
  input  logic [31:0]       inst_sram_rdata,
  input  logic              ds_allowin,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              fs_to_ds_valid,
  output logic [31:0]       fs_to_ds_pc,
  output logic [31:0]       fs_to_ds_inst,
  output logic [PERF_W-1:0] fetch_cnt
);

  logic [31:0] pc_r;
  logic [31:0] fs_pc;
  logic        fs_valid;
  logic        buf_valid;
  logic [31:0] inst_buf;
  // Set in the cycle after a request: inst_sram_rdata belongs to fs_pc now.
  logic        data_fresh;

  logic [31:0] next_pc;
  logic        fs_allowin;
  logic        issue;
  logic        handoff;
  logic        capture;

  always_comb begin
    next_pc        = br_taken ? br_target : pc_r + 32'd4;
    fs_allowin     = !fs_valid || (ds_allowin && !br_taken);
    issue          = resetn && (fs_allowin || br_taken);
    fs_to_ds_valid = fs_valid && !br_taken && resetn;
    handoff        = fs_to_ds_valid && ds_allowin;
    // Only the first stalled cycle sees live SRAM data; grab it then.
    capture        = fs_valid && data_fresh && !ds_allowin && !br_taken;

    inst_sram_en    = issue;
    inst_sram_we    = 1'b0;
    inst_sram_wdata = '0;
    inst_sram_addr  = issue ? next_pc : pc_r;

    fs_to_ds_pc   = fs_pc;
    fs_to_ds_inst = buf_valid ? inst_buf : inst_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r       <= RESET_PC - 32'd4;
      fs_pc      <= '0;
      fs_valid   <= 1'b0;
      buf_valid  <= 1'b0;
      inst_buf   <= '0;
      data_fresh <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      if (issue) begin
        pc_r       <= next_pc;
        fs_pc      <= next_pc;
        fs_valid   <= 1'b1;
        data_fresh <= 1'b1;
        buf_valid  <= 1'b0;
      end else begin
        data_fresh <= 1'b0;
        if (capture) begin
          inst_buf  <= inst_sram_rdata;
          buf_valid <= 1'b1;
        end
      end
      if (handoff) begin
        fetch_cnt <= fetch_cnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, decode stall with
// buffered instruction, redirects (plain and during stall), reset mid-stall,
// and PC wrap at the top of the address space.
module tb_fetch_stage;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic [31:0] fetch_cnt;

  int passed;
  int total;

  fetch_stage #(.RESET_PC(32'h1c000000), .PERF_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_pc    (fs_to_ds_pc),
    .fs_to_ds_inst  (fs_to_ds_inst),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a5a5a;
  endfunction

  // SRAM model: one-cycle latency; garbage whenever no request was made.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? word(inst_sram_addr) : 32'hbad0bad0;
  end

  task automatic drive(input logic rn, input logic al, input logic br, input logic [31:0] tg);
    @(negedge clk);
    resetn     = rn;
    ds_allowin = al;
    br_taken   = br;
    br_target  = tg;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (inst_sram_en !== 1'b0) $display("FAIL rst_en got %b exp 0", inst_sram_en); else passed++;
      total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", fs_to_ds_valid); else passed++;
    end
    total++; if (fetch_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", fetch_cnt); else passed++;
    total++; if (inst_sram_we !== 1'b0) $display("FAIL rst_we got %b exp 0", inst_sram_we); else passed++;
    total++; if (inst_sram_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", inst_sram_wdata); else passed++;
  endtask

  task automatic test_sequential;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (inst_sram_en !== 1'b1) $display("FAIL seq_en0 got %b exp 1", inst_sram_en); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000000) $display("FAIL seq_addr0 got %h exp 1c000000", inst_sram_addr); else passed++;
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL seq_valid0 got %b exp 0", fs_to_ds_valid); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b1) $display("FAIL seq_valid1 got %b exp 1", fs_to_ds_valid); else passed++;
    total++; if (fs_to_ds_pc !== 32'h1c000000) $display("FAIL seq_pc1 got %h exp 1c000000", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000000)) $display("FAIL seq_inst1 got %h exp %h", fs_to_ds_inst, word(32'h1c000000)); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000004) $display("FAIL seq_addr1 got %h exp 1c000004", inst_sram_addr); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'h1c000004) $display("FAIL seq_pc2 got %h exp 1c000004", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000004)) $display("FAIL seq_inst2 got %h exp %h", fs_to_ds_inst, word(32'h1c000004)); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000008) $display("FAIL seq_addr2 got %h exp 1c000008", inst_sram_addr); else passed++;
    total++; if (fetch_cnt !== 32'd1) $display("FAIL seq_cnt1 got %0d exp 1", fetch_cnt); else passed++;
  endtask

  task automatic test_stall;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      total++; if (fs_to_ds_valid !== 1'b1) $display("FAIL stall_valid%0d got %b exp 1", i, fs_to_ds_valid); else passed++;
      total++; if (fs_to_ds_pc !== 32'h1c000008) $display("FAIL stall_pc%0d got %h exp 1c000008", i, fs_to_ds_pc); else passed++;
      total++; if (fs_to_ds_inst !== word(32'h1c000008)) $display("FAIL stall_inst%0d got %h exp %h", i, fs_to_ds_inst, word(32'h1c000008)); else passed++;
      total++; if (inst_sram_en !== 1'b0) $display("FAIL stall_en%0d got %b exp 0", i, inst_sram_en); else passed++;
      total++; if (fetch_cnt !== 32'd2) $display("FAIL stall_cnt%0d got %0d exp 2", i, fetch_cnt); else passed++;
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'h1c000008) $display("FAIL rel_pc got %h exp 1c000008", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000008)) $display("FAIL rel_inst got %h exp %h", fs_to_ds_inst, word(32'h1c000008)); else passed++;
    total++; if (inst_sram_en !== 1'b1) $display("FAIL rel_en got %b exp 1", inst_sram_en); else passed++;
    total++; if (inst_sram_addr !== 32'h1c00000c) $display("FAIL rel_addr got %h exp 1c00000c", inst_sram_addr); else passed++;
  endtask

  task automatic test_redirect;
    drive(1'b1, 1'b1, 1'b1, 32'h1c000100);
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL br_valid got %b exp 0", fs_to_ds_valid); else passed++;
    total++; if (fs_to_ds_pc !== 32'h1c00000c) $display("FAIL br_heldpc got %h exp 1c00000c", fs_to_ds_pc); else passed++;
    total++; if (inst_sram_en !== 1'b1) $display("FAIL br_en got %b exp 1", inst_sram_en); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000100) $display("FAIL br_addr got %h exp 1c000100", inst_sram_addr); else passed++;
    total++; if (fetch_cnt !== 32'd3) $display("FAIL br_cnt got %0d exp 3", fetch_cnt); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b1) $display("FAIL brt_valid got %b exp 1", fs_to_ds_valid); else passed++;
    total++; if (fs_to_ds_pc !== 32'h1c000100) $display("FAIL brt_pc got %h exp 1c000100", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000100)) $display("FAIL brt_inst got %h exp %h", fs_to_ds_inst, word(32'h1c000100)); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000104) $display("FAIL brt_addr got %h exp 1c000104", inst_sram_addr); else passed++;
    total++; if (fetch_cnt !== 32'd3) $display("FAIL brt_cnt got %0d exp 3", fetch_cnt); else passed++;
  endtask

  task automatic test_redirect_stall;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'h1c000104) $display("FAIL brs_pc got %h exp 1c000104", fs_to_ds_pc); else passed++;
    total++; if (fetch_cnt !== 32'd4) $display("FAIL brs_cnt got %0d exp 4", fetch_cnt); else passed++;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_inst !== word(32'h1c000104)) $display("FAIL brs_buf got %h exp %h", fs_to_ds_inst, word(32'h1c000104)); else passed++;
    drive(1'b1, 1'b0, 1'b1, 32'h1c000200);
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL brs_valid got %b exp 0", fs_to_ds_valid); else passed++;
    total++; if (inst_sram_en !== 1'b1) $display("FAIL brs_en got %b exp 1", inst_sram_en); else passed++;
    total++; if (inst_sram_addr !== 32'h1c000200) $display("FAIL brs_addr got %h exp 1c000200", inst_sram_addr); else passed++;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b1) $display("FAIL brs_tvalid got %b exp 1", fs_to_ds_valid); else passed++;
    total++; if (fs_to_ds_pc !== 32'h1c000200) $display("FAIL brs_tpc got %h exp 1c000200", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000200)) $display("FAIL brs_tinst got %h exp %h", fs_to_ds_inst, word(32'h1c000200)); else passed++;
    total++; if (inst_sram_en !== 1'b0) $display("FAIL brs_ten got %b exp 0", inst_sram_en); else passed++;
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL rms_valid got %b exp 0", fs_to_ds_valid); else passed++;
    total++; if (inst_sram_en !== 1'b0) $display("FAIL rms_en got %b exp 0", inst_sram_en); else passed++;
    drive(1'b0, 1'b1, 1'b1, 32'h1c000300);
    total++; if (inst_sram_en !== 1'b0) $display("FAIL rms_bren got %b exp 0", inst_sram_en); else passed++;
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL rms_brvalid got %b exp 0", fs_to_ds_valid); else passed++;
    total++; if (fetch_cnt !== 32'd0) $display("FAIL rms_cnt got %0d exp 0", fetch_cnt); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (inst_sram_addr !== 32'h1c000000) $display("FAIL rms_addr got %h exp 1c000000", inst_sram_addr); else passed++;
    total++; if (inst_sram_en !== 1'b1) $display("FAIL rms_en1 got %b exp 1", inst_sram_en); else passed++;
    total++; if (fs_to_ds_valid !== 1'b0) $display("FAIL rms_valid1 got %b exp 0", fs_to_ds_valid); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'h1c000000) $display("FAIL rms_pc got %h exp 1c000000", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h1c000000)) $display("FAIL rms_inst got %h exp %h", fs_to_ds_inst, word(32'h1c000000)); else passed++;
  endtask

  task automatic test_wrap;
    drive(1'b1, 1'b1, 1'b1, 32'hfffffffc);
    total++; if (inst_sram_addr !== 32'hfffffffc) $display("FAIL wrap_addr0 got %h exp fffffffc", inst_sram_addr); else passed++;
    total++; if (fetch_cnt !== 32'd1) $display("FAIL wrap_cnt1 got %0d exp 1", fetch_cnt); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'hfffffffc) $display("FAIL wrap_pc0 got %h exp fffffffc", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'hfffffffc)) $display("FAIL wrap_inst0 got %h exp %h", fs_to_ds_inst, word(32'hfffffffc)); else passed++;
    total++; if (inst_sram_addr !== 32'h00000000) $display("FAIL wrap_addr1 got %h exp 00000000", inst_sram_addr); else passed++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_pc !== 32'h00000000) $display("FAIL wrap_pc1 got %h exp 00000000", fs_to_ds_pc); else passed++;
    total++; if (fs_to_ds_inst !== word(32'h00000000)) $display("FAIL wrap_inst1 got %h exp %h", fs_to_ds_inst, word(32'h00000000)); else passed++;
    total++; if (fetch_cnt !== 32'd2) $display("FAIL wrap_cnt2 got %0d exp 2", fetch_cnt); else passed++;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_reset_mid_stall;
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
